// File: rtl/imem_pkg.sv
// Shared constants and response-entry type for the instruction fetch memory.
// Build option: IMEM_ALIGN_CHECK_EN adds a misalign flag to each response.
package imem_pkg;

    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_ADDR_W = 8;

    localparam logic [IMEM_DATA_W-1:0] NOP = '0;

    typedef struct packed {
`ifdef IMEM_ALIGN_CHECK_EN
        logic                   misalign;
`endif
        logic [IMEM_ADDR_W-1:0] addr;
        logic [IMEM_DATA_W-1:0] instr;
    } rsp_t;

endpackage

// File: rtl/imem_skid_buf.sv
// Two-entry response queue: output register plus one skid entry.
// Accepts a push whenever the skid entry is free.
module imem_skid_buf
    import imem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic push,
    input  rsp_t push_data,
    output logic push_ready,
    output logic out_valid,
    input  logic out_ready,
    output rsp_t out_data
);

    logic skid_valid;
    rsp_t skid_data;
    logic pop;

    assign push_ready = !skid_valid;
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || pop) begin
            // Output slot frees up: skid entry has priority over new data.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= push;
                if (push) begin
                    skid_data <= push_data;
                end
            end else if (push) begin
                out_data  <= push_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            skid_data  <= push_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with 1-cycle registered fetch and skid-buffered responses.
// Build option: IMEM_ALIGN_CHECK_EN enables misaligned fetch/load handling.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
`ifdef IMEM_ALIGN_CHECK_EN
    output logic              rsp_misalign,
`endif
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] mem [DEPTH];

    logic        buf_ready;
    logic        push;
    logic        load_ok;
    logic [DATA_W-1:0] rd_word;
    rsp_t        push_data;
    rsp_t        out_data;

    assign rd_word   = mem[req_addr[ADDR_W-1:2]];
    assign req_ready = buf_ready && !flush;
    assign push      = req_valid && req_ready;

`ifdef IMEM_ALIGN_CHECK_EN
    assign load_ok = (load_addr[1:0] == 2'b00);

    always_comb begin
        push_data          = '0;
        push_data.misalign = (req_addr[1:0] != 2'b00);
        push_data.addr     = req_addr;
        push_data.instr    = push_data.misalign ? NOP : rd_word;
    end

    assign rsp_misalign = out_data.misalign;
`else
    logic unused_lo;

    assign load_ok   = 1'b1;
    assign unused_lo = ^load_addr[1:0];

    always_comb begin
        push_data       = '0;
        push_data.addr  = req_addr;
        push_data.instr = rd_word;
    end
`endif

    // Storage is deliberately not reset; a fetch sees pre-write data.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            mem[load_addr[ADDR_W-1:2]] <= load_data;
        end
    end

    imem_skid_buf u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .push       (push),
        .push_data  (push_data),
        .push_ready (buf_ready),
        .out_valid  (rsp_valid),
        .out_ready  (rsp_ready),
        .out_data   (out_data)
    );

    assign rsp_instr = out_data.instr;
    assign rsp_addr  = out_data.addr;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: driver pushes expected responses,
// a negedge monitor pops and compares each delivered response.
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [7:0]  rsp_addr;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
`ifdef IMEM_ALIGN_CHECK_EN
    logic        rsp_misalign;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  addr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_fetch_mem dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .flush        (flush),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_instr    (rsp_instr),
        .rsp_addr     (rsp_addr),
`ifdef IMEM_ALIGN_CHECK_EN
        .rsp_misalign (rsp_misalign),
`endif
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed at the next posedge when valid&&ready.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got addr %h instr %h expected none",
                         rsp_addr, rsp_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_instr", rsp_instr, e.instr);
                chk("rsp_addr", {24'h0, rsp_addr}, {24'h0, e.addr});
`ifdef IMEM_ALIGN_CHECK_EN
                chk("rsp_misalign", {31'h0, rsp_misalign}, {31'h0, e.mis});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [31:0] ei,
                         input logic em);
        exp_t e;
        bit   done;
        e.instr   = ei;
        e.addr    = a;
        e.mis     = em;
        req_valid = 1'b1;
        req_addr  = a;
        done      = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            step();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: addr %h not accepted expected accept", a);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        step();
        step();
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_instr", rsp_instr, 32'h0);
        chk("reset_rsp_addr", {24'h0, rsp_addr}, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        step();

        load(8'h00, 32'hAAAA0000);
        load(8'h04, 32'hBBBB0004);
        load(8'h08, 32'hE3A01005);
        load(8'h10, 32'h22222222);
        load(8'hFC, 32'hCAFE00FC);

        // Single fetch with latency 1
        fetch(8'h08, 32'hE3A01005, 1'b0);
        @(negedge clk);
        chk("lat1_valid", {31'h0, rsp_valid}, 32'h1);
        step();
        step();

        // Back-to-back, one per cycle
        fetch(8'h00, 32'hAAAA0000, 1'b0);
        fetch(8'h04, 32'hBBBB0004, 1'b0);
        fetch(8'h08, 32'hE3A01005, 1'b0);
        step();
        step();

        // Backpressure fills both entries
        rsp_ready = 1'b0;
        fetch(8'h00, 32'hAAAA0000, 1'b0);
        fetch(8'h04, 32'hBBBB0004, 1'b0);
        req_valid = 1'b1;
        req_addr  = 8'h08;
        @(negedge clk);
        chk("full_req_ready", {31'h0, req_ready}, 32'h0);
        step();
        chk("full_hold_addr", {24'h0, rsp_addr}, 32'h00);
        rsp_ready = 1'b1;
        fetch(8'h08, 32'hE3A01005, 1'b0);
        step();
        step();

        // Flush with a request in the same cycle
        rsp_ready = 1'b0;
        fetch(8'h00, 32'hAAAA0000, 1'b0);
        fetch(8'h04, 32'hBBBB0004, 1'b0);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 8'h08;
        @(negedge clk);
        chk("flush_req_ready", {31'h0, req_ready}, 32'h0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Same-cycle load and fetch returns old data
        load_en   = 1'b1;
        load_addr = 8'h10;
        load_data = 32'h11111111;
        fetch(8'h10, 32'h22222222, 1'b0);
        load_en = 1'b0;
        fetch(8'h10, 32'h11111111, 1'b0);

        // Top word boundary
        fetch(8'hFC, 32'hCAFE00FC, 1'b0);

`ifdef IMEM_ALIGN_CHECK_EN
        fetch(8'h06, 32'h00000000, 1'b1);
        load(8'h09, 32'hDEADBEEF);
        fetch(8'h08, 32'hE3A01005, 1'b0);
`else
        fetch(8'h0B, 32'hE3A01005, 1'b0);
`endif
        step();
        step();

        // Reset mid-stream
        rsp_ready = 1'b0;
        fetch(8'h00, 32'hAAAA0000, 1'b0);
        chk("pre_reset_valid", {31'h0, rsp_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midreset_instr", rsp_instr, 32'h0);
        exp_q.delete();
        step();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        fetch(8'h04, 32'hBBBB0004, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, byte-address width; depth = 2**(ADDR_W-2) words.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  fetch request present.
REQ-006 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_addr  in  ADDR_W  byte address of fetch.
REQ-008 SHALL have port flush  in  1  discard all pending and in-flight responses.
REQ-009 SHALL have port rsp_valid  out  1  response present.
REQ-010 SHALL have port rsp_ready  in  1  consumer takes response when high with rsp_valid.
REQ-011 SHALL have port rsp_instr  out  DATA_W  fetched word.
REQ-012 SHALL have port rsp_addr  out  ADDR_W  byte address the response belongs to.
REQ-013 SHALL have port load_en  in  1  write strobe for program load.
REQ-014 SHALL have port load_addr  in  ADDR_W  byte address of load write.
REQ-015 SHALL have port load_data  in  DATA_W  word written.

Function
REQ-016 SHALL index storage with addr[ADDR_W-1:2] (word addressing) for both read and load.
REQ-017 SHALL register the read: accepted request at edge N yields rsp_valid with its word after edge N+1 (latency 1).
REQ-018 SHALL buffer responses in a 2-entry queue (output register + skid entry); req_ready = skid entry empty.
REQ-019 SHALL hold rsp_instr/rsp_addr stable while rsp_valid && !rsp_ready.
REQ-020 SHALL, with queue full and rsp_ready low, deassert req_ready and accept nothing.
REQ-021 SHALL, on accept and pop in the same cycle with queue at 1 entry, sustain one response per cycle.
REQ-022 SHALL, on flush, empty the queue and cancel any in-flight read at the next edge; rsp_valid low the following cycle.
REQ-023 SHALL, on flush and req_valid in the same cycle, drop the request (req_ready forced low).
REQ-024 SHALL perform load writes at the edge when load_en is high, independent of the fetch handshake.
REQ-025 SHALL, on a load and fetch to the same word in the same cycle, return the old (pre-write) data.
REQ-026 SHALL wrap addresses modulo depth; no out-of-range behaviour exists.

Reset
REQ-027 SHALL, while reset_n low, force rsp_valid=0, queue empty, req_ready=1 (after release), rsp_instr=0, rsp_addr=0.
REQ-028 SHALL NOT reset storage contents; reset mid-operation drops all pending responses.

Configuration
REQ-029 SHALL, with IMEM_ALIGN_CHECK_EN defined, return NOP (0x00000000) and assert output rsp_misalign (1 bit, reset 0) for a request with req_addr[1:0] != 0; load writes with load_addr[1:0] != 0 are ignored.
REQ-030 SHALL, without IMEM_ALIGN_CHECK_EN, ignore addr[1:0] everywhere and omit port rsp_misalign.

Structure
REQ-031 SHALL take NOP constant, default DATA_W/ADDR_W and response-entry struct from package imem_pkg.
REQ-032 SHALL implement the 2-entry queue as sub-module imem_skid_buf.

Verification
REQ-033 Load 0xE3A01005 at 0x08, fetch 0x08 with rsp_ready=1 -> rsp_valid next cycle, rsp_instr=0xE3A01005, rsp_addr=0x08.
REQ-034 Back-to-back fetch 0x00,0x04,0x08 with rsp_ready=1 -> three consecutive responses, one per cycle, in order.
REQ-035 rsp_ready=0, fetch 0x00,0x04,0x08 -> two accepted, req_ready low on third; raise rsp_ready -> 0x00 then 0x04 delivered, then 0x08 accepted.
REQ-036 Queue holding 2 entries, flush=1 one cycle -> rsp_valid=0 next cycle, no stale response afterwards.
REQ-037 Same-cycle load 0x11111111 and fetch at 0x10 (old 0x22222222) -> response 0x22222222; refetch -> 0x11111111.
REQ-038 With IMEM_ALIGN_CHECK_EN, fetch 0x06 -> rsp_instr=0x00000000, rsp_misalign=1; reset asserted mid-stream -> rsp_valid=0 immediately.
